// File: rtl/sobel_stream_pipe.sv
// Streaming 3x3 Sobel edge magnitude over raster-order frames with valid/ready on both sides.
// Optional SOBEL_THRESH_EN macro binarises the output against THRESH.
module sobel_stream_pipe #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int THRESH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;

  if (IMG_W < 3 || IMG_H < 3 || THRESH < 0) begin : g_param_check
    $error("sobel_stream_pipe: IMG_W/IMG_H must be >= 3 and THRESH non-negative");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and in_ready depends only on out_ready and out_valid.
  logic             accept;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] lb_top [IMG_W];
  logic [PIX_W-1:0] lb_mid [IMG_W];
  logic [PIX_W-1:0] win [3][2];
  logic [PIX_W-1:0] col_top, col_mid;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]    abs_x, abs_y, mag;
  logic [PIX_W-1:0] mag_sat, result;
  logic             emit, frame_end;

  assign in_ready = out_ready | ~out_valid;
  assign accept   = in_valid & in_ready;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // win holds columns c-2 and c-1; the incoming column completes the 3x3 neighbourhood.
  assign col_top = lb_top[col];
  assign col_mid = lb_mid[col];

  always_comb begin
    gx = (ext(col_top) + (ext(col_mid) <<< 1) + ext(in_pixel))
       - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(in_pixel))
       - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(col_top));
    abs_x = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_y = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag   = abs_x + abs_y;
    mag_sat = (|mag[GW-1:PIX_W]) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
  end

`ifdef SOBEL_THRESH_EN
  assign result = ({3'b000, mag_sat} >= GW'(THRESH)) ? {PIX_W{1'b1}} : '0;
`else
  assign result = mag_sat;
`endif

  assign emit      = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign frame_end = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pixel <= '0;
    end else begin
      if (accept) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_pixel <= result;
        out_last  <= frame_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Storage is never reset: the counters keep stale rows/columns out of every result.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col] <= col_mid;
      lb_mid[col] <= in_pixel;
      for (int i = 0; i < 3; i++) win[i][0] <= win[i][1];
      win[0][1] <= col_top;
      win[1][1] <= col_mid;
      win[2][1] <= in_pixel;
    end
  end

endmodule
